// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg
// Shared types for the ALU sequencer: opcode and FSM state encodings, plus
// helpers classifying which opcodes touch the flags and which write R[rd].
package alu_seq_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_SHL  = 4'd2,
        OP_SHR  = 4'd3,
        OP_CMP  = 4'd4,
        OP_AND  = 4'd5,
        OP_OR   = 4'd6,
        OP_XOR  = 4'd7,
        OP_NAND = 4'd8,
        OP_NOR  = 4'd9,
        OP_XNOR = 4'd10,
        OP_INV  = 4'd11,
        OP_NEG  = 4'd12,
        OP_STO  = 4'd13,
        OP_SWP  = 4'd14,
        OP_LOAD = 4'd15
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_EXEC,
        S_WRITE,
        S_WRITE2
    } state_e;

    // Every ALU opcode (ADD..NEG) updates flags; the data-movement ops do not.
    function automatic logic updates_flags(input op_e op);
        return !(op == OP_STO || op == OP_SWP || op == OP_LOAD);
    endfunction

    // CMP only sets flags and STO only drives dout; everything else writes rd.
    function automatic logic writes_rd(input op_e op);
        return !(op == OP_CMP || op == OP_STO);
    endfunction

endpackage

// File: rtl/alu_core.sv
// alu_core
// Combinational 16-operation ALU. Data-movement opcodes (STO/SWP/LOAD) pass
// A through; their result is never used for flags.
// Ports:
//   op     : opcode
//   a, b   : operands (unary ops use a only)
//   result : WIDTH-bit result
//   c      : carry / borrow / shifted-out bit
//   z, n   : zero and MSB of result
module alu_core
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  op_e              op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             c,
    output logic             z,
    output logic             n
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    assign sum  = {1'b0, a} + {1'b0, b};
    // Top bit of the extended difference is the unsigned borrow (a < b).
    assign diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        result = a;
        c      = 1'b0;
        unique case (op)
            OP_ADD:  begin result = sum[WIDTH-1:0];  c = sum[WIDTH];  end
            OP_SUB,
            OP_CMP:  begin result = diff[WIDTH-1:0]; c = diff[WIDTH]; end
            OP_SHL:  begin result = {a[WIDTH-2:0], 1'b0}; c = a[WIDTH-1]; end
            OP_SHR:  begin result = {1'b0, a[WIDTH-1:1]}; c = a[0]; end
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_NAND: result = ~(a & b);
            OP_NOR:  result = ~(a | b);
            OP_XNOR: result = ~(a ^ b);
            OP_INV:  result = ~a;
            OP_NEG:  begin result = '0 - a; c = |a; end
            default: result = a;
        endcase
    end

    assign z = ~|result;
    assign n = result[WIDTH-1];

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer
// Multi-cycle controller: accepts one instruction in IDLE, reads operands
// from the inline register file (READ), latches the ALU result (EXEC), then
// commits register/flag/dout updates (WRITE, plus WRITE2 for SWP).
// Ports:
//   clk, rst                 : clock, async active-high reset
//   instr_valid/instr_ready  : instruction handshake (ready only in IDLE)
//   instr_op/rd/rs/imm       : instruction fields
//   done                     : one-cycle pulse when instruction retires
//   flag_z/flag_c/flag_n     : status flags
//   dout, dout_valid         : STO output register and its pulse
//   dbg_addr, dbg_data       : combinational register file peek
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int REG_AW = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [3:0]        instr_op,
    input  logic [REG_AW-1:0] instr_rd,
    input  logic [REG_AW-1:0] instr_rs,
    input  logic [WIDTH-1:0]  instr_imm,
    output logic              done,
    output logic              flag_z,
    output logic              flag_c,
    output logic              flag_n,
    output logic [WIDTH-1:0]  dout,
    output logic              dout_valid,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [WIDTH-1:0]  dbg_data
);

    localparam int NREGS = 1 << REG_AW;

    state_e            state, state_nx;
    op_e               op_q;
    logic [REG_AW-1:0] rd_q, rs_q;
    logic [WIDTH-1:0]  imm_q, a_q, b_q, res_q;
    logic              zn_q, cn_q, nn_q;     // flags computed in EXEC
    logic [WIDTH-1:0]  regs [NREGS];

    logic [WIDTH-1:0]  alu_res;
    logic              alu_c, alu_z, alu_n;

    logic              we;
    logic [REG_AW-1:0] waddr;
    logic [WIDTH-1:0]  wdata;

    alu_core #(.WIDTH(WIDTH)) u_alu (
        .op     (op_q),
        .a      (a_q),
        .b      (b_q),
        .result (alu_res),
        .c      (alu_c),
        .z      (alu_z),
        .n      (alu_n)
    );

    assign instr_ready = (state == S_IDLE);
    assign dbg_data    = regs[dbg_addr];

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:   if (instr_valid) state_nx = S_READ;
            S_READ:   state_nx = S_EXEC;
            S_EXEC:   state_nx = S_WRITE;
            S_WRITE:  state_nx = (op_q == OP_SWP) ? S_WRITE2 : S_IDLE;
            S_WRITE2: state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    // Single write port: rd in WRITE, rs in WRITE2 (SWP second half).
    always_comb begin
        we    = 1'b0;
        waddr = rd_q;
        wdata = res_q;
        if (state == S_WRITE && writes_rd(op_q)) begin
            we = 1'b1;
            if (op_q == OP_LOAD)     wdata = imm_q;
            else if (op_q == OP_SWP) wdata = b_q;
        end else if (state == S_WRITE2) begin
            we    = 1'b1;
            waddr = rs_q;
            wdata = a_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    // ---------------- Datapath ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q       <= OP_ADD;
            rd_q       <= '0;
            rs_q       <= '0;
            imm_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            res_q      <= '0;
            zn_q       <= 1'b0;
            cn_q       <= 1'b0;
            nn_q       <= 1'b0;
            flag_z     <= 1'b0;
            flag_c     <= 1'b0;
            flag_n     <= 1'b0;
            dout       <= '0;
            done       <= 1'b0;
            dout_valid <= 1'b0;
        end else begin
            done       <= (state == S_WRITE && op_q != OP_SWP) || (state == S_WRITE2);
            dout_valid <= (state == S_WRITE && op_q == OP_STO);
            unique case (state)
                S_IDLE: if (instr_valid) begin
                    op_q  <= op_e'(instr_op);
                    rd_q  <= instr_rd;
                    rs_q  <= instr_rs;
                    imm_q <= instr_imm;
                end
                S_READ: begin
                    a_q <= regs[rd_q];
                    b_q <= regs[rs_q];
                end
                S_EXEC: begin
                    res_q <= alu_res;
                    zn_q  <= alu_z;
                    cn_q  <= alu_c;
                    nn_q  <= alu_n;
                end
                S_WRITE: begin
                    if (updates_flags(op_q)) begin
                        flag_z <= zn_q;
                        flag_c <= cn_q;
                        flag_n <= nn_q;
                    end
                    if (op_q == OP_STO) dout <= a_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
module tb_alu_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       instr_valid = 1'b0;
    logic       instr_ready;
    logic [3:0] instr_op = '0;
    logic [1:0] instr_rd = '0;
    logic [1:0] instr_rs = '0;
    logic [7:0] instr_imm = '0;
    logic       done, flag_z, flag_c, flag_n, dout_valid;
    logic [7:0] dout;
    logic [1:0] dbg_addr = '0;
    logic [7:0] dbg_data;

    int vectors = 0;
    int miscompares = 0;
    int accepts = 0;

    // Reference model state
    int unsigned m [4];
    int unsigned mz, mc, mn, mdout;

    alu_sequencer #(.WIDTH(8), .REG_AW(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_op    (instr_op),
        .instr_rd    (instr_rd),
        .instr_rs    (instr_rs),
        .instr_imm   (instr_imm),
        .done        (done),
        .flag_z      (flag_z),
        .flag_c      (flag_c),
        .flag_n      (flag_n),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (!rst && instr_valid && instr_ready) accepts++;

    task automatic check(input string tag, input logic [31:0] obs, input int unsigned exp);
        vectors++;
        assert (obs === 32'(exp)) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic peek(input int r, output logic [7:0] v);
        dbg_addr = 2'(r);
        #1;
        v = dbg_data;
    endtask

    task automatic chk_reg(input string tag, input int r, input int unsigned v);
        logic [7:0] x;
        peek(r, x);
        check(tag, {24'd0, x}, v);
    endtask

    task automatic chk_flags(input string tag, input int z, input int c, input int n);
        check({tag, ".z"}, {31'd0, flag_z}, z);
        check({tag, ".c"}, {31'd0, flag_c}, c);
        check({tag, ".n"}, {31'd0, flag_n}, n);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m[i] = 0;
        mz = 0; mc = 0; mn = 0; mdout = 0;
    endtask

    // Behavioural model: computes the effect of one instruction from the
    // opcode rules using plain integer arithmetic on 8-bit values.
    task automatic model(input int op, input int rd, input int rs, input int unsigned imm);
        int unsigned a, b, res, c;
        bit fl;
        a = m[rd]; b = m[rs]; res = a; c = 0; fl = 1;
        case (op)
            0:  begin res = (a + b) % 256; c = (a + b > 255) ? 1 : 0; end
            1, 4: begin res = (a + 256 - b) % 256; c = (a < b) ? 1 : 0; end
            2:  begin res = (a * 2) % 256; c = a / 128; end
            3:  begin res = a / 2; c = a % 2; end
            5:  res = a & b;
            6:  res = a | b;
            7:  res = a ^ b;
            8:  res = 255 - (a & b);
            9:  res = 255 - (a | b);
            10: res = 255 - (a ^ b);
            11: res = 255 - a;
            12: begin res = (256 - a) % 256; c = (a != 0) ? 1 : 0; end
            default: fl = 0;
        endcase
        if (fl) begin
            mz = (res == 0) ? 1 : 0;
            mn = res / 128;
            mc = c;
        end
        case (op)
            13: mdout = a;
            14: begin m[rd] = b; m[rs] = a; end
            15: m[rd] = imm;
            4:  ;
            default: m[rd] = res;
        endcase
    endtask

    task automatic check_model(input string tag);
        for (int r = 0; r < 4; r++) begin
            logic [7:0] x;
            peek(r, x);
            check($sformatf("%s.R%0d", tag, r), {24'd0, x}, m[r]);
        end
        chk_flags(tag, int'(mz), int'(mc), int'(mn));
        check({tag, ".dout"}, {24'd0, dout}, mdout);
    endtask

    // Issue one instruction starting from IDLE (called #1 after an edge).
    // instr_valid stays high through the busy cycles to show they are ignored.
    task automatic run(input string tag, input int op, input int rd, input int rs,
                       input int unsigned imm);
        int n, acc0, lat;
        lat = (op == 14) ? 5 : 4;
        instr_op = 4'(op); instr_rd = 2'(rd); instr_rs = 2'(rs); instr_imm = 8'(imm);
        instr_valid = 1'b1;
        acc0 = accepts;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!done && n < 12);
        instr_valid = 1'b0;
        check({tag, ".lat"}, 32'(n), lat);
        check({tag, ".accepts"}, 32'(accepts - acc0), 1);
        check({tag, ".dout_valid"}, {31'd0, dout_valid}, (op == 13) ? 1 : 0);
        check({tag, ".ready"}, {31'd0, instr_ready}, 1);
        model(op, rd, rs, imm);
        check_model(tag);
    endtask

    task automatic chk_reset_state(input string tag);
        check({tag, ".ready"}, {31'd0, instr_ready}, 1);
        check({tag, ".done"}, {31'd0, done}, 0);
        check({tag, ".dout_valid"}, {31'd0, dout_valid}, 0);
        check({tag, ".dout"}, {24'd0, dout}, 0);
        chk_flags(tag, 0, 0, 0);
        for (int r = 0; r < 4; r++) chk_reg($sformatf("%s.R%0d", tag, r), r, 0);
    endtask

    initial begin
        // Reset
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk_reset_state("reset");
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        // ADD with carry-out to zero
        run("ld_r0", 15, 0, 0, 8'h0F);
        run("ld_r1", 15, 1, 0, 8'hF1);
        run("add", 0, 0, 1, 0);
        chk_reg("add.R0k", 0, 8'h00);
        chk_flags("add.k", 1, 1, 0);

        // CMP then SUB
        run("ld_r2", 15, 2, 0, 8'h05);
        run("ld_r3", 15, 3, 0, 8'h07);
        run("cmp", 4, 2, 3, 0);
        chk_reg("cmp.R2k", 2, 8'h05);
        chk_reg("cmp.R3k", 3, 8'h07);
        chk_flags("cmp.k", 0, 1, 1);
        run("sub", 1, 3, 2, 0);
        chk_reg("sub.R3k", 3, 8'h02);
        chk_flags("sub.k", 0, 0, 0);

        // Shifts and negate
        run("ld_81", 15, 0, 0, 8'h81);
        run("shl", 2, 0, 0, 0);
        chk_reg("shl.R0k", 0, 8'h02);
        check("shl.ck", {31'd0, flag_c}, 1);
        run("shr", 3, 0, 0, 0);
        chk_reg("shr.R0k", 0, 8'h01);
        check("shr.ck", {31'd0, flag_c}, 0);
        run("neg", 12, 0, 0, 0);
        chk_reg("neg.R0k", 0, 8'hFF);
        chk_flags("neg.k", 0, 1, 1);

        // Swap (flags must stay from NEG)
        run("ld_aa", 15, 1, 0, 8'hAA);
        run("ld_55", 15, 2, 0, 8'h55);
        run("swp", 14, 1, 2, 0);
        chk_reg("swp.R1k", 1, 8'h55);
        chk_reg("swp.R2k", 2, 8'hAA);
        chk_flags("swp.k", 0, 1, 1);
        run("swp_same", 14, 3, 3, 0);
        chk_reg("swp_same.R3k", 3, 8'h02);

        // Store
        run("sto", 13, 2, 0, 0);
        check("sto.doutk", {24'd0, dout}, 8'hAA);
        @(posedge clk); #1;
        check("sto.dv_pulse", {31'd0, dout_valid}, 0);
        check("sto.done_pulse", {31'd0, done}, 0);

        // Reset during EXEC of an ADD: nothing committed
        instr_op = 4'd0; instr_rd = 2'd1; instr_rs = 2'd2; instr_valid = 1'b1;
        @(posedge clk); #1;              // READ
        instr_valid = 1'b0;
        @(posedge clk); #1;              // EXEC
        rst = 1'b1;
        #1;
        model_reset();
        chk_reset_state("midrst");
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        run("post_rst_ld", 15, 1, 0, 8'h3C);
        chk_reg("post_rst.R1k", 1, 8'h3C);

        // Randomized instructions against the model
        for (int i = 0; i < 60; i++) begin
            run($sformatf("rnd%0d", i), int'($urandom_range(0, 15)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                $urandom_range(0, 255));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
